prefetch_fetch_unit: RTL and testbench

PREFETCH_FETCH_UNIT -- requirements
Module: prefetch_fetch_unit

---
 rtl/prefetch_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_prefetch_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit
// Instruction prefetcher. It issues sequential fetches to an instruction memory
// and tracks the address of every outstanding request in issue order. Returned
// instructions are buffered in a small queue and handed to the consumer with
// their addresses. A redirect flushes the queue and restarts fetch at a new PC.
// Responses to requests issued before a redirect are still accepted from the
// memory, but they are dropped instead of queued.
//
// Credit rule: queue occupancy plus every outstanding request, including those
// already marked for drop, never exceeds DEPTH. This keeps the queue from
// overflowing and bounds the address record to DEPTH entries.
module prefetch_fetch_unit #(
    parameter int              PC_W     = 12,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch address
    logic [PC_W-1:0]    fetch_pc;

    // Address record of issued requests (oldest at rec_rd)
    logic [PC_W-1:0]    rec_addr [DEPTH];
    logic [PTR_W-1:0]   rec_wr;
    logic [PTR_W-1:0]   rec_rd;
    logic [CNT_W-1:0]   outstanding;   // all issued requests awaiting a response
    logic [CNT_W-1:0]   drop_cnt;      // oldest outstanding requests to discard

    // Prefetch queue
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PC_W-1:0]    q_pc    [DEPTH];
    logic [PTR_W-1:0]   q_head;
    logic [PTR_W-1:0]   q_tail;
    logic [CNT_W-1:0]   q_count;

    // Handshake decode
    logic [CNT_W:0]     credit_used;
    logic               issue;
    logic               resp;
    logic               dropping;
    logic               push;
    logic               pop;

    // Credit is consumed by queued entries and by every outstanding request,
    // dropped or not, so an accepted response always has a free queue slot.
    assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req    = !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign issue       = imem_req && imem_ready;

    // A response without an outstanding request is ignored by the datapath.
    assign resp        = imem_rvalid && (outstanding != '0);
    assign dropping    = (drop_cnt != '0);

    // Redirect overrides push and pop: the queue is emptied on that edge.
    assign push        = resp && !dropping && !redirect_valid;
    assign pop         = out_valid && out_ready && !redirect_valid;

    // Queue head drives the outputs. Gating with out_valid gives zeros while
    // empty (and so during reset) without resetting the storage arrays.
    assign out_valid   = (q_count != '0);
    assign out_instr   = out_valid ? q_instr[q_head] : '0;
    assign out_pc      = out_valid ? q_pc[q_head]    : '0;
    assign count       = q_count;

    // Fetch PC: restart on redirect, otherwise advance on each issued request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (issue) begin
            fetch_pc <= fetch_pc + PC_W'(1);
        end
    end

    // Address record pointers, outstanding count and drop accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_wr      <= '0;
            rec_rd      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (issue) begin
                rec_wr <= rec_wr + PTR_W'(1);
            end
            if (resp) begin
                rec_rd <= rec_rd + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
            if (redirect_valid) begin
                // Everything still outstanding after this edge belongs to the
                // old stream; a response arriving now is consumed and discarded.
                // No request issues on a redirect cycle.
                drop_cnt <= outstanding - CNT_W'(resp);
            end else if (resp && dropping) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Record the address of each issued request
    always_ff @(posedge clk) begin
        if (issue) begin
            rec_addr[rec_wr] <= fetch_pc;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else if (redirect_valid) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                q_tail <= q_tail + PTR_W'(1);
            end
            if (pop) begin
                q_head <= q_head + PTR_W'(1);
            end
            q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Write accepted responses at the tail, paired with the oldest recorded address
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[q_tail] <= imem_rdata;
            q_pc[q_tail]    <= rec_addr[rec_rd];
        end
    end

`ifndef SYNTHESIS
    // Flag a read response that has no matching outstanding request
    always_ff @(posedge clk) begin
        if (!reset && imem_rvalid) begin
            assert (outstanding != '0)
                else $error("prefetch_fetch_unit: imem_rvalid with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb_prefetch_fetch_unit
// Table-driven and sequence checks for prefetch_fetch_unit. Main instance uses
// RESET_PC=0 with a memory model of programmable latency; a second instance
// uses RESET_PC=0xFFE with a fixed 1-cycle memory to exercise PC wrap.
module tb_prefetch_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [11:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;

    logic        b_req;
    logic [11:0] b_addr;
    logic        b_ready;
    logic        b_rvalid;
    logic [15:0] b_rdata;
    logic        b_redirect;
    logic [11:0] b_redirect_pc;
    logic        b_valid;
    logic [15:0] b_instr;
    logic [11:0] b_pc;
    logic        b_out_ready;
    logic [2:0]  b_count;

    prefetch_fetch_unit #(.PC_W(12), .INSTR_W(16), .DEPTH(4), .RESET_PC(12'h000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .count(count)
    );

    prefetch_fetch_unit #(.PC_W(12), .INSTR_W(16), .DEPTH(4), .RESET_PC(12'hFFE)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ready(b_ready),
        .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
        .redirect_valid(b_redirect), .redirect_pc(b_redirect_pc),
        .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc),
        .out_ready(b_out_ready), .count(b_count)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc;
    int          lat;
    logic [11:0] got[$];
    logic [11:0] got_b[$];
    bit          b_pend;
    logic [11:0] b_pend_addr;
    bit          b_capture;
    int          nresets;
    bit          vhist[64];

    typedef struct {
        bit          do_reset;
        bit          ordy;
        bit          e_req;
        logic [11:0] e_addr;
        bit          e_valid;
        logic [11:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tab[16];

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return {4'hA, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive memory responses, then let combinational outputs settle.
    task automatic cyc_begin();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        b_rvalid = b_pend;
        b_rdata  = b_pend ? mem_word(b_pend_addr) : '0;
        #1;
    endtask

    // Record this cycle's issues and pops, then advance to the next falling edge.
    task automatic cyc_end();
        if (imem_req && imem_ready) mq.push_back('{imem_addr, cyc + lat});
        if (out_valid && out_ready && !redirect_valid) begin
            got.push_back(out_pc);
            chk($sformatf("pop_instr_pc%0h", out_pc), out_instr, mem_word(out_pc));
        end
        if (b_capture && b_valid && b_out_ready) got_b.push_back(b_pc);
        b_pend      = b_req && b_ready;
        b_pend_addr = b_addr;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset applied mid-cycle; outputs are checked before any clock edge.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_out_pc", out_pc, 12'h000);
        chk("rst_out_instr", out_instr, 16'h0000);
        chk("rst_imem_addr", imem_addr, 12'h000);
        chk("rst_wrap_addr", b_addr, 12'hFFE);
        chk("rst_wrap_valid", b_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        b_rvalid    = 1'b0;
        b_pend      = 1'b0;
        mq.delete();
        got.delete();
        cyc         = 0;
        b_capture   = (nresets == 0);
        nresets++;
    endtask

    task automatic run_seq(input int n, input bit ordy,
                           input int r1, input logic [11:0] p1,
                           input int r2, input logic [11:0] p2);
        for (int c = 0; c < n; c++) begin
            redirect_valid = (c == r1) || (c == r2);
            redirect_pc    = (c == r1) ? p1 : p2;
            out_ready      = ordy;
            cyc_begin();
            vhist[c] = out_valid;
            cyc_end();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n;

        // Phase 1: 1-cycle memory, consumer always ready.
        tab[0]  = '{1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 3'd0};
        tab[1]  = '{1'b0, 1'b1, 1'b1, 12'h001, 1'b0, 12'h000, 3'd0};
        tab[2]  = '{1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 12'h000, 3'd1};
        tab[3]  = '{1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 12'h001, 3'd1};
        tab[4]  = '{1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 12'h002, 3'd1};
        tab[5]  = '{1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 12'h003, 3'd1};
        tab[6]  = '{1'b0, 1'b1, 1'b1, 12'h006, 1'b1, 12'h004, 3'd1};
        // Phase 2: consumer stalled, queue fills to 4, then drains.
        tab[7]  = '{1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 3'd0};
        tab[8]  = '{1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 12'h000, 3'd0};
        tab[9]  = '{1'b0, 1'b0, 1'b1, 12'h002, 1'b1, 12'h000, 3'd1};
        tab[10] = '{1'b0, 1'b0, 1'b1, 12'h003, 1'b1, 12'h000, 3'd2};
        tab[11] = '{1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 12'h000, 3'd3};
        tab[12] = '{1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 12'h000, 3'd4};
        tab[13] = '{1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 12'h000, 3'd4};
        tab[14] = '{1'b0, 1'b1, 1'b0, 12'h004, 1'b1, 12'h000, 3'd4};
        tab[15] = '{1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 12'h001, 3'd3};

        reset          = 1'b1;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        b_ready        = 1'b1;
        b_rvalid       = 1'b0;
        b_rdata        = '0;
        b_redirect     = 1'b0;
        b_redirect_pc  = '0;
        b_out_ready    = 1'b1;
        b_pend         = 1'b0;
        b_pend_addr    = '0;
        b_capture      = 1'b0;
        nresets        = 0;
        cyc            = 0;
        lat            = 1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (tab[i].do_reset) begin
                if (i == 7) begin
                    chk("seq_len", (got.size() >= 5), 1'b1);
                    for (int k = 0; k < 5 && k < got.size(); k++)
                        chk($sformatf("seq_pc%0d", k), got[k], 12'(k));
                    chk("wrap_len", (got_b.size() >= 4), 1'b1);
                    if (got_b.size() >= 4) begin
                        chk("wrap_pc0", got_b[0], 12'hFFE);
                        chk("wrap_pc1", got_b[1], 12'hFFF);
                        chk("wrap_pc2", got_b[2], 12'h000);
                        chk("wrap_pc3", got_b[3], 12'h001);
                    end
                end
                lat = 1;
                do_reset();
            end
            out_ready = tab[i].ordy;
            cyc_begin();
            chk($sformatf("row%0d_req", i), imem_req, tab[i].e_req);
            chk($sformatf("row%0d_addr", i), imem_addr, tab[i].e_addr);
            chk($sformatf("row%0d_valid", i), out_valid, tab[i].e_valid);
            chk($sformatf("row%0d_count", i), count, tab[i].e_cnt);
            if (tab[i].e_valid) begin
                chk($sformatf("row%0d_pc", i), out_pc, tab[i].e_pc);
                chk($sformatf("row%0d_instr", i), out_instr, mem_word(tab[i].e_pc));
            end
            cyc_end();
        end

        // Latency 3, redirect to 0x080 with three requests outstanding.
        lat = 3;
        do_reset();
        run_seq(12, 1'b1, 3, 12'h080, -1, 12'h000);
        n = 0;
        for (int c = 0; c <= 7; c++) if (vhist[c]) n++;
        chk("redir_queue_empty", n, 0);
        chk("redir_len", (got.size() >= 3), 1'b1);
        if (got.size() >= 3) begin
            chk("redir_pc0", got[0], 12'h080);
            chk("redir_pc1", got[1], 12'h081);
            chk("redir_pc2", got[2], 12'h082);
        end

        // Back-to-back redirects 0x100 then 0x200, latency 3.
        lat = 3;
        do_reset();
        run_seq(13, 1'b1, 3, 12'h100, 4, 12'h200);
        chk("b2b_len", (got.size() >= 3), 1'b1);
        if (got.size() >= 3) begin
            chk("b2b_pc0", got[0], 12'h200);
            chk("b2b_pc1", got[1], 12'h201);
            chk("b2b_pc2", got[2], 12'h202);
        end

        // Reset during activity: two queued entries and two requests outstanding.
        lat = 3;
        do_reset();
        run_seq(5, 1'b0, -1, 12'h000, -1, 12'h000);
        chk("pre_reset_count", count, 3'd2);
        chk("pre_reset_req", imem_req, 1'b0);
        lat = 1;
        do_reset();
        cyc_begin();
        chk("post_reset_req", imem_req, 1'b1);
        chk("post_reset_addr", imem_addr, 12'h000);
        cyc_end();
        run_seq(5, 1'b1, -1, 12'h000, -1, 12'h000);
        chk("post_reset_len", (got.size() >= 3), 1'b1);
        if (got.size() >= 3) begin
            chk("post_reset_pc0", got[0], 12'h000);
            chk("post_reset_pc1", got[1], 12'h001);
            chk("post_reset_pc2", got[2], 12'h002);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
